// File: rtl/plab2_proc_fetch_unit_pkg.sv
// Shared fetch front-end definitions: widths,
// reset vector and buffered response layout.
package plab2_proc_fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int ENTRY_W = 64;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h1000;

  typedef struct packed {
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/plab2_proc_fetch_unit_if.sv
// Fetch unit handshake bundle: imem request/response,
// redirect from control, and the val/rdy path into D.
interface plab2_proc_fetch_unit_if;
  import plab2_proc_fetch_unit_pkg::*;

  logic            imemreq_val;
  logic            imemreq_rdy;
  logic [XLEN-1:0] imemreq_msg_addr;
  logic            imemresp_val;
  logic            imemresp_rdy;
  logic [XLEN-1:0] imemresp_msg_data;
  logic            redirect_val;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_val_D;
  logic            inst_rdy_D;
  logic [XLEN-1:0] inst_D;
  logic [XLEN-1:0] pc_plus4_D;

  modport master (
    output imemreq_val, imemreq_msg_addr,
    input  imemreq_rdy,
    input  imemresp_val, imemresp_msg_data,
    output imemresp_rdy,
    input  redirect_val, redirect_pc,
    output inst_val_D, inst_D, pc_plus4_D,
    input  inst_rdy_D
  );

  modport slave (
    input  imemreq_val, imemreq_msg_addr,
    output imemreq_rdy,
    output imemresp_val, imemresp_msg_data,
    input  imemresp_rdy,
    output redirect_val, redirect_pc,
    input  inst_val_D, inst_D, pc_plus4_D,
    output inst_rdy_D
  );

endinterface

// File: rtl/plab2_proc_fetch_buffer.sv
// Small circular FIFO with synchronous flush;
// head reads as zero while empty.
module plab2_proc_fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_val,
  input  logic [WIDTH-1:0]           enq_data,
  input  logic                       deq_val,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_enq;
  logic             do_deq;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (occ == CW'(DEPTH));
  assign empty  = (occ == '0);
  assign do_enq = enq_val && !full;
  assign do_deq = deq_val && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_enq) wr_ptr <= inc(wr_ptr);
      if (do_deq) rd_ptr <= inc(rd_ptr);
      if (do_enq && !do_deq)
        occ <= occ + CW'(1);
      else if (!do_enq && do_deq)
        occ <= occ - CW'(1);
    end
  end

endmodule

// File: rtl/plab2_proc_fetch_unit.sv
// Decoupled fetch front end: credit-limited imem issue,
// in-order response buffering and redirect squashing.
module plab2_proc_fetch_unit
  import plab2_proc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] p_reset_vector = RESET_VECTOR,
  parameter int              p_max_inflight = 2,
  parameter int              p_buf_depth    = 2
) (
  input logic                      clk,
  input logic                      reset,
  plab2_proc_fetch_unit_if.master  fetch
);

  localparam int TCW = $clog2(p_max_inflight + 1);
  localparam int RCW = $clog2(p_buf_depth + 1);

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] tag_head;
  logic [TCW-1:0]  inflight_cnt;
  logic [TCW-1:0]  drop_cnt;
  logic [TCW-1:0]  tag_occ;
  logic [RCW-1:0]  occ;
  logic [3:0]      live;
  logic [3:0]      occ_eff;
  fetch_entry_t    head;
  fetch_entry_t    enq_entry;
  logic            req_fire;
  logic            resp_fire;
  logic            resp_live;
  logic            deq_fire;
  logic            rsp_empty;
  logic            rsp_full;
  logic            tag_full;
  logic            tag_empty;
  logic            unused_ok;

  assign addr = fetch.redirect_val
              ? fetch.redirect_pc : pc_next;
  assign fetch.imemreq_msg_addr = addr;
  assign fetch.imemresp_rdy     = reset;

  assign fetch.inst_val_D = !rsp_empty
                         && !fetch.redirect_val;
  assign fetch.inst_D     = head.inst;
  assign fetch.pc_plus4_D = head.pc_plus4;

  assign deq_fire  = fetch.inst_val_D
                  && fetch.inst_rdy_D;
  assign resp_fire = fetch.imemresp_val
                  && fetch.imemresp_rdy;
  assign resp_live = resp_fire && (drop_cnt == '0);

  // Credits count what survives this edge: a slot being
  // dequeued is free, and a redirect kills all live work.
  assign live    = fetch.redirect_val ? 4'd0
                 : 4'(inflight_cnt) - 4'(drop_cnt);
  assign occ_eff = fetch.redirect_val ? 4'd0
                 : 4'(occ) - 4'(deq_fire);

  assign fetch.imemreq_val = reset
    && (inflight_cnt < TCW'(p_max_inflight))
    && (live + occ_eff < 4'(p_buf_depth));

  assign req_fire = fetch.imemreq_val
                 && fetch.imemreq_rdy;

  assign enq_entry = '{
    pc_plus4: tag_head + 32'd4,
    inst:     fetch.imemresp_msg_data
  };

  assign unused_ok = ^{rsp_full, tag_full,
                       tag_empty, tag_occ};

  plab2_proc_fetch_buffer #(
    .DEPTH (p_buf_depth),
    .WIDTH (ENTRY_W)
  ) u_resp_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (fetch.redirect_val),
    .enq_val  (resp_live),
    .enq_data (enq_entry),
    .deq_val  (deq_fire),
    .head     (head),
    .full     (rsp_full),
    .empty    (rsp_empty),
    .occ      (occ)
  );

  plab2_proc_fetch_buffer #(
    .DEPTH (p_max_inflight),
    .WIDTH (XLEN)
  ) u_tag_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (1'b0),
    .enq_val  (req_fire),
    .enq_data (addr),
    .deq_val  (resp_fire),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .occ      (tag_occ)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_next      <= p_reset_vector;
      inflight_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (req_fire)
        pc_next <= addr + 32'd4;
      else if (fetch.redirect_val)
        pc_next <= fetch.redirect_pc;
      inflight_cnt <= inflight_cnt
                    + TCW'(req_fire)
                    - TCW'(resp_fire);
      if (fetch.redirect_val)
        drop_cnt <= inflight_cnt - TCW'(resp_fire);
      else if (resp_fire && drop_cnt != '0)
        drop_cnt <= drop_cnt - TCW'(1);
    end
  end

endmodule

// File: tb/tb_plab2_proc_fetch_unit.sv
// Fetch unit bench: directed and random traffic against
// an epoch-based fetch-stream scoreboard.
module tb_plab2_proc_fetch_unit;
  import plab2_proc_fetch_unit_pkg::*;

  localparam int MAX_INFL = 2;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  plab2_proc_fetch_unit_if fif ();

  plab2_proc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .fetch (fif)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          lat      = 1;
  logic [31:0] key      = '0;
  logic [31:0] arch_next = RESET_VECTOR;
  req_t        pend[$];
  exp_t        exp_q[$];
  logic        s_req_val, s_req_fire;
  logic        s_dval, s_d_fire;
  logic [31:0] s_addr, s_inst, s_pc4;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h",
               nm, act, req);
    end
  endfunction

  // One cycle: drive at negedge, sample 1 ns later and
  // update the memory model and expected D stream.
  task automatic step(input bit redir,
                      input logic [31:0] rpc,
                      input bit drdy,
                      input bit mrdy);
    req_t r;
    @(negedge clk);
    cyc++;
    fif.redirect_val = redir;
    fif.redirect_pc  = rpc;
    fif.inst_rdy_D   = drdy;
    fif.imemreq_rdy  = mrdy;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      fif.imemresp_val      = 1'b1;
      fif.imemresp_msg_data = pend[0].addr ^ key;
    end else begin
      fif.imemresp_val      = 1'b0;
      fif.imemresp_msg_data = $urandom;
    end
    #1;
    s_req_val  = fif.imemreq_val;
    s_addr     = fif.imemreq_msg_addr;
    s_req_fire = s_req_val && mrdy;
    s_dval     = fif.inst_val_D;
    s_d_fire   = s_dval && drdy;
    s_inst     = fif.inst_D;
    s_pc4      = fif.pc_plus4_D;
    if (redir) begin
      chk("redirect_hides_head", {31'd0, s_dval}, 32'd0);
      epoch++;
      exp_q.delete();
      arch_next = rpc;
    end
    if (s_req_fire)
      chk("inflight_limit",
          {31'd0, pend.size() < MAX_INFL}, 32'd1);
    if (fif.imemresp_val) begin
      chk("resp_rdy", {31'd0, fif.imemresp_rdy}, 32'd1);
      if (fif.imemresp_rdy) begin
        r = pend.pop_front();
        if (r.epoch == epoch)
          exp_q.push_back('{inst: r.addr ^ key,
                            pc4:  r.addr + 32'd4});
      end
    end
    if (s_req_fire)
      pend.push_back('{addr: s_addr, epoch: epoch,
                       due: cyc + lat});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (reset && fif.inst_val_D && fif.inst_rdy_D) begin
      if (exp_q.size() == 0) begin
        chk("d_unexpected_count", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("d_inst", fif.inst_D, e.inst);
        chk("d_pc_plus4", fif.pc_plus4_D, e.pc4);
      end
      chk("d_pc_sequence", fif.pc_plus4_D,
          arch_next + 32'd4);
      arch_next = fif.pc_plus4_D;
    end
  end

  task automatic do_reset();
    reset                 = 1'b0;
    fif.imemresp_val      = 1'b1;
    fif.imemresp_msg_data = 32'hBAD0_BAD0;
    fif.imemreq_rdy       = 1'b1;
    fif.redirect_val      = 1'b0;
    fif.redirect_pc       = '0;
    fif.inst_rdy_D        = 1'b1;
    pend.delete();
    exp_q.delete();
    epoch++;
    arch_next = RESET_VECTOR;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_val", {31'd0, fif.imemreq_val}, 32'd0);
    chk("rst_resp_rdy", {31'd0, fif.imemresp_rdy}, 32'd0);
    chk("rst_inst_val", {31'd0, fif.inst_val_D}, 32'd0);
    chk("rst_inst", fif.inst_D, 32'd0);
    chk("rst_pc_plus4", fif.pc_plus4_D, 32'd0);
    fif.imemresp_val = 1'b0;
    fif.imemreq_rdy  = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_d(input string nm,
                        input logic [31:0] inst,
                        input logic [31:0] pc4,
                        input int min_k);
    int k;
    k = 0;
    do begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      k++;
    end while (!s_d_fire && k < 12);
    chk({nm, "_seen"}, {31'd0, s_d_fire}, 32'd1);
    chk({nm, "_inst"}, s_inst, inst);
    chk({nm, "_pc4"}, s_pc4, pc4);
    chk({nm, "_latency"}, {31'd0, k >= min_k}, 32'd1);
  endtask

  task automatic drain(input string nm);
    repeat (12) step(1'b0, 32'd0, 1'b1, 1'b0);
    chk({nm, "_exp_empty"}, exp_q.size(), 32'd0);
    chk({nm, "_pend_empty"}, pend.size(), 32'd0);
    chk({nm, "_dval_low"}, {31'd0, s_dval}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=%0d required=0", 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fires;
    int reqs;
    int n;
    do_reset();

    // straight-line fetch, 1-cycle memory
    lat   = 1;
    fires = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      if (i == 0) begin
        chk("first_req_val", {31'd0, s_req_val}, 32'd1);
        chk("first_req_addr", s_addr, 32'h1000);
      end
      if (i == 2) begin
        chk("first_inst", s_inst, 32'h1000);
        chk("first_pc4", s_pc4, 32'h1004);
      end
      if (i >= 2 && s_d_fire) fires++;
    end
    chk("straight_throughput", fires, 32'd22);

    // backpressure
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd0, 1'b0, 1'b1);
      if (i >= 1 && s_req_fire) reqs++;
    end
    chk("bp_req_blocked", {31'd0, s_req_val}, 32'd0);
    chk("bp_head_valid", {31'd0, s_dval}, 32'd1);
    chk("bp_req_count", reqs, 32'd0);
    repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1);

    // redirect with two outstanding, 2-cycle memory
    lat = 2;
    n   = 0;
    while (pend.size() != 2 && n < 20) begin
      step(1'b0, 32'd0, 1'b1, 1'b1);
      n++;
    end
    chk("pend_two", pend.size(), 32'd2);
    step(1'b1, 32'h2000, 1'b1, 1'b1);
    wait_d("redirect", 32'h2000, 32'h2004, 2);

    // redirect racing a response and a D dequeue
    lat = 1;
    repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'h3000, 1'b1, 1'b1);
    chk("race_req_fire", {31'd0, s_req_fire}, 32'd1);
    chk("race_req_addr", s_addr, 32'h3000);
    wait_d("race", 32'h3000, 32'h3004, 2);

    // PC wrap
    repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    chk("wrap_req_fire", {31'd0, s_req_fire}, 32'd1);
    chk("wrap_req_addr", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("wrap_next_fire", {31'd0, s_req_fire}, 32'd1);
    chk("wrap_next_addr", s_addr, 32'h0000_0000);
    wait_d("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1);

    // randomized traffic
    key = 32'hC3A5_0000;
    for (int i = 0; i < 800; i++) begin
      lat = $urandom_range(1, 3);
      step($urandom_range(0, 15) == 0,
           $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) != 0);
    end
    drain("rand_drain");

    // reset mid-stream
    key = '0;
    lat = 2;
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1);
    do_reset();
    lat = 1;
    step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("restart_req_val", {31'd0, s_req_val}, 32'd1);
    chk("restart_req_addr", s_addr, 32'h1000);
    repeat (10) step(1'b0, 32'd0, 1'b1, 1'b1);
    drain("restart_drain");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
